// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
package arb_types;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   function automatic logic is_serving(arb_state_t s);
      return (s == SERVE_I) || (s == SERVE_D);
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto one shared memory port.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of D priority.
module mem_arbiter
   import arb_types::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              d_req;
   logic              grant_i;
   logic              grant_d;
   logic              serving;

   assign d_req   = d_read | d_write;
   assign serving = is_serving(state_q);

`ifdef ARB_ROUND_ROBIN_EN
   // rr_q high means D is favoured on the next collision
   logic rr_q, rr_d;

   // Grant decision: alternate on collisions, single requests pass through
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == IDLE) begin
         if (d_req && i_read) begin
            grant_d = rr_q;
            grant_i = ~rr_q;
         end else begin
            grant_d = d_req;
            grant_i = i_read;
         end
      end
   end

   // Pointer moves to the other side after every grant
   always_comb begin
      rr_d = rr_q;
      if (grant_d) rr_d = 1'b0;
      if (grant_i) rr_d = 1'b1;
   end

   // Pointer register, resets to I-favoured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= 1'b0;
      else        rr_q <= rr_d;
   end
`else
   // Grant decision: D-cache always wins a collision
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == IDLE) begin
         grant_d = d_req;
         grant_i = i_read & ~d_req;
      end
   end
`endif

   // Next state and transaction capture on leaving IDLE
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = SERVE_D;
               addr_d  = d_address;
               wr_d    = d_write;
               if (d_write) wdata_d = d_wdata;
            end else if (grant_i) begin
               state_d = SERVE_I;
               addr_d  = i_address;
               wr_d    = 1'b0;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched transaction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   end

   // Memory side sees only the latched transaction, only while serving
   always_comb begin
      pmem_read    = serving & ~wr_q;
      pmem_write   = serving & wr_q;
      pmem_address = serving ? addr_q : '0;
      pmem_wdata   = (serving & wr_q) ? wdata_q : '0;
   end

   // Completion pulses follow pmem_resp in the serving state only
   always_comb begin
      i_resp  = (state_q == SERVE_I) & pmem_resp;
      d_resp  = (state_q == SERVE_D) & pmem_resp;
      i_rdata = pmem_rdata;
      d_rdata = pmem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model.
// Expectations cover both builds via ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int LW  = 256;
   localparam int LAT = 3;

   logic          clk;
   logic          rst_n;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   int total = 0;
   int bad   = 0;
   int mcnt  = 0;
   logic force_resp = 1'b0;

   typedef struct {
      bit            is_d;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } exp_t;

   exp_t q[$];

   mem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [LW-1:0] mem_line(logic [AW-1:0] a);
      if (a == 32'h100) return {32{8'hA5}};
      return {8{a}};
   endfunction

   task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push(bit is_d, bit wr, logic [AW-1:0] a, logic [LW-1:0] d);
      exp_t e;
      e.is_d = is_d;
      e.wr   = wr;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 80 && q.size() != 0; k++) begin
         @(negedge clk);
         #1;
      end
      check("drain_timeout", LW'(q.size()), '0);
      q.delete();
   endtask

   // Memory model: respond on the LAT-th cycle of a held strobe
   initial begin
      int cnt;
      cnt = 0;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pmem_read || pmem_write) cnt++;
         else cnt = 0;
         if (cnt == LAT) begin
            pmem_resp  = 1'b1;
            pmem_rdata = mem_line(pmem_address);
         end else begin
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
         end
         if (force_resp) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {32{8'h3C}};
         end
      end
   end

   // Monitor: pop and compare on every completion pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (i_resp || d_resp) begin
            mcnt++;
            check("resp_exclusive", LW'(i_resp & d_resp), '0);
            if (q.size() == 0) begin
               check("unexpected_resp", LW'({i_resp, d_resp}), '0);
            end else begin
               e = q.pop_front();
               check("resp_side", LW'({i_resp, d_resp}),
                     LW'({~e.is_d, e.is_d}));
               check("resp_addr", LW'(pmem_address), LW'(e.addr));
               check("resp_wr", LW'({pmem_write, pmem_read}),
                     LW'({e.wr, ~e.wr}));
               if (e.wr)
                  check("resp_wdata", pmem_wdata, e.data);
               else if (e.is_d)
                  check("resp_drdata", d_rdata, e.data);
               else
                  check("resp_irdata", i_rdata, e.data);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] wd;
      wd = {8{32'hDEAD_BEEF}};
      rst_n = 1'b0;
      i_read = 1'b0;
      i_address = '0;
      d_read = 1'b0;
      d_write = 1'b0;
      d_address = '0;
      d_wdata = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", LW'({pmem_read, pmem_write}), '0);
      check("rst_resps", LW'({i_resp, d_resp}), '0);
      check("rst_addr", LW'(pmem_address), '0);
      tick();
      rst_n = 1'b1;
      tick();

      // lone I read, 3-cycle memory latency
      i_read = 1'b1;
      i_address = 32'h100;
      push(1'b0, 1'b0, 32'h100, {32{8'hA5}});
      tick();
      i_read = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("t1_read_c%0d", c), LW'(pmem_read),
               LW'(c <= 3));
         if (c == 1) check("t1_addr", LW'(pmem_address), LW'(32'h100));
      end
      drain();
      tick();

      // simultaneous I read and D write-back
      i_read = 1'b1;
      i_address = 32'h400;
      d_write = 1'b1;
      d_address = 32'h500;
      d_wdata = wd;
      push(1'b1, 1'b1, 32'h500, wd);
      push(1'b0, 1'b0, 32'h400, mem_line(32'h400));
      tick();
      d_write = 1'b0;
      @(negedge clk);
      check("t2_write", LW'({pmem_write, pmem_read}), LW'(2'b10));
      check("t2_wdata", pmem_wdata, wd);
      check("t2_waddr", LW'(pmem_address), LW'(32'h500));
      tick();
      tick();
      tick();
      @(negedge clk);
      check("t2_gap_idle", LW'({pmem_write, pmem_read}), '0);
      tick();
      i_read = 1'b0;
      @(negedge clk);
      check("t2_i_read", LW'(pmem_read), LW'(1));
      check("t2_i_addr", LW'(pmem_address), LW'(32'h400));
      drain();
      tick();

      // continuous collisions from a fresh reset
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      i_read = 1'b1;
      i_address = 32'h600;
      d_read = 1'b1;
      d_address = 32'h700;
`ifdef ARB_ROUND_ROBIN_EN
      push(1'b0, 1'b0, 32'h600, mem_line(32'h600));
      push(1'b1, 1'b0, 32'h700, mem_line(32'h700));
      push(1'b0, 1'b0, 32'h600, mem_line(32'h600));
      push(1'b1, 1'b0, 32'h700, mem_line(32'h700));
`else
      for (int n = 0; n < 4; n++)
         push(1'b1, 1'b0, 32'h700, mem_line(32'h700));
`endif
      drain();
      i_read = 1'b0;
      d_read = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("t3_quiet", LW'({pmem_write, pmem_read}), '0);

      // address change mid-transaction
      tick();
      d_read = 1'b1;
      d_address = 32'h200;
      push(1'b1, 1'b0, 32'h200, mem_line(32'h200));
      tick();
      d_read = 1'b0;
      d_address = 32'h300;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("t4_addr_c%0d", c), LW'(pmem_address),
               LW'(32'h200));
      end
      drain();
      tick();

      // reset during SERVE_I
      i_read = 1'b1;
      i_address = 32'h800;
      tick();
      i_read = 1'b0;
      @(negedge clk);
      check("t5_pre_read", LW'(pmem_read), LW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_drop", LW'({pmem_read, pmem_write}), '0);
      check("t5_async_addr", LW'(pmem_address), '0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      check("t5_no_resp", LW'(q.size()), '0);
      i_read = 1'b1;
      i_address = 32'h900;
      push(1'b0, 1'b0, 32'h900, mem_line(32'h900));
      tick();
      i_read = 1'b0;
      @(negedge clk);
      check("t5_next_addr", LW'(pmem_address), LW'(32'h900));
      drain();
      tick();
      tick();

      // stray pmem_resp while idle
      @(negedge clk);
      #2;
      force_resp = 1'b1;
      @(negedge clk);
      check("t6_resp_seen", LW'(pmem_resp), LW'(1));
      check("t6_no_pulse", LW'({i_resp, d_resp}), '0);
      #2;
      force_resp = 1'b0;
      @(negedge clk);
      check("t6_still_idle", LW'({pmem_read, pmem_write}), '0);
      check("t6_mon_count", LW'(mcnt), LW'(9));

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical address width in bits.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_read  input  1  I-cache line-fill request.
REQ-006 SHALL have port i_address  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  I-cache fill data.
REQ-008 SHALL have port i_resp  output  1  I-cache transaction done.
REQ-009 SHALL have port d_read  input  1  D-cache line-fill request.
REQ-010 SHALL have port d_write  input  1  D-cache write-back request.
REQ-011 SHALL have port d_address  input  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  D-cache write-back data.
REQ-013 SHALL have port d_rdata  output  LINE_W  D-cache fill data.
REQ-014 SHALL have port d_resp  output  1  D-cache transaction done.
REQ-015 SHALL have port pmem_read  output  1  shared-memory read strobe.
REQ-016 SHALL have port pmem_write  output  1  shared-memory write strobe.
REQ-017 SHALL have port pmem_address  output  ADDR_W  shared-memory address.
REQ-018 SHALL have port pmem_wdata  output  LINE_W  shared-memory write data.
REQ-019 SHALL have port pmem_rdata  input  LINE_W  shared-memory read data.
REQ-020 SHALL have port pmem_resp  input  1  shared-memory done, one-cycle pulse.

Function
REQ-021 SHALL implement an FSM with states IDLE, SERVE_I and SERVE_D.
REQ-022 In IDLE: with d_read|d_write asserted, the FSM SHALL go to SERVE_D; otherwise with i_read asserted, to SERVE_I; otherwise it SHALL stay in IDLE.
REQ-023 On leaving IDLE, the FSM SHALL latch the winning requester's address, direction and (if a write) wdata into internal registers.
REQ-024 pmem_read/pmem_write, pmem_address and pmem_wdata SHALL be driven only from the latched registers, and only while in SERVE_I or SERVE_D.
REQ-025 pmem_read/pmem_write SHALL assert the cycle after the request was sampled in IDLE (one-cycle grant latency), and SHALL hold until pmem_resp.
REQ-026 In SERVE_x with pmem_resp=1, the arbiter SHALL pulse x_resp high for that same cycle (combinational), and SHALL return to IDLE on the next edge.
REQ-027 i_rdata and d_rdata SHALL both pass pmem_rdata through continuously; only the resp signals qualify the data.
REQ-028 A requester that changes or drops its request mid-transaction SHALL NOT affect pmem_* outputs; the latched transaction SHALL complete, and its resp pulse SHALL still be issued.
REQ-029 d_read and d_write asserted together SHALL be treated as a write.
REQ-030 The FSM SHALL spend at least one IDLE cycle between transactions; back-to-back requests therefore see a 2-cycle minimum turnaround.
REQ-031 pmem_resp received in IDLE SHALL be ignored, and SHALL produce no resp pulse.
REQ-032 i_resp and d_resp SHALL never be high in the same cycle.

Reset
REQ-033 Asserting rst_n low SHALL immediately force: FSM=IDLE, latched registers=0, pmem_read=pmem_write=0, i_resp=d_resp=0, rr pointer=I-favoured.
REQ-034 Reset asserted mid-transaction SHALL abandon that transaction; no resp pulse SHALL follow after reset deassertion.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-036 With ARB_ROUND_ROBIN_EN defined, simultaneous I and D requests in IDLE SHALL be granted to the side not served last (a 1-bit pointer, updated on each grant); single requests SHALL be granted directly.
REQ-037 Without ARB_ROUND_ROBIN_EN, REQ-022 fixed D priority SHALL apply, and no pointer register SHALL exist.

Structure
REQ-038 Package arb_types SHALL hold the state enum arb_state_t {IDLE, SERVE_I, SERVE_D} and the default ADDR_W and LINE_W constants.
REQ-039 Single module; no sub-module is required (the round-robin pointer is one flop inside mem_arbiter).

Verification
REQ-040 Lone i_read, i_address=0x0000_0100, pmem_resp after 3 cycles, pmem_rdata=0xA5..A5 -> pmem_read high cycles 1-3, pmem_address=0x100, i_resp pulse with i_rdata=0xA5..A5, d_resp=0.
REQ-041 i_read and d_write in the same IDLE cycle, without the macro -> D write-back served first (pmem_write, d_wdata on pmem_wdata), then I served after a single IDLE cycle.
REQ-042 With ARB_ROUND_ROBIN_EN, both requesting continuously for 4 transactions -> grant order I, D, I, D.
REQ-043 d_address changed from 0x200 to 0x300 mid-SERVE_D -> pmem_address stays 0x200 until pmem_resp.
REQ-044 rst_n pulsed low during SERVE_I -> pmem_read drops asynchronously, no i_resp after release, next i_read served normally.
REQ-045 pmem_resp pulsed in IDLE with no requests -> no resp pulse and no state change.
